usr_deser: RTL and testbench
============================

USR_DESER -- requirements
Module: usr_deser

Interface
REQ-001 Parameter W, default 8, is the data bits per frame; legal range 2..16.
REQ-002 Port clk, input, 1 bit: the only clock; all state updates on the rising edge.
REQ-003 Port clr, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port ser_in, input, 1 bit: serial data, LSB first, driven from the upstream shift register's serial output.
REQ-005 Port ser_en, input, 1 bit: ser_in is valid this cycle; a bit is consumed only when ser_en=1.
REQ-006 Port ser_start, input, 1 bit: qualifies the current ser_en bit as bit 0 of a new frame; ignored when ser_en=0.
REQ-007 Port byte_out, output, W bits: assembled word, bit 0 = first received bit.
REQ-008 Port byte_valid, output, 1 bit: byte_out holds an unconsumed word.
REQ-009 Port byte_ready, input, 1 bit: consumer accepts byte_out on any edge where byte_valid=1.
REQ-010 Port busy, output, 1 bit: a frame is in progress, i.e. state is not IDLE.
REQ-011 Port overrun, output, 1 bit: one-cycle pulse when a completed word is dropped.
REQ-012 Port frame_abort, output, 1 bit: one-cycle pulse when a partial frame is discarded by a restart.
REQ-013 Port parity_err, output, 1 bit: parity result that accompanies byte_out (see REQ-027 and REQ-028).

Function
REQ-014 States SHALL be IDLE, DATA and PAR; PAR exists only under REQ-027.
REQ-015 IDLE: on ser_en=1 with ser_start=1, capture ser_in as bit 0, set bit count to 1, go to DATA; ser_en=1 with ser_start=0 is discarded.
REQ-016 DATA: on ser_en=1, shift the bit in at the MSB (shift register <= {ser_in, shift[W-1:1]}) and increment the count.
REQ-017 ser_en=0 SHALL hold all state; gaps of any length between bits are legal.
REQ-018 Completion is the edge that samples bit W-1; with parity disabled, the FSM returns to IDLE on that edge.
REQ-019 On completion the word SHALL load into a separate output register, so a new frame may begin on the very next cycle.
REQ-020 Latency: byte_valid is 1 in the cycle immediately after the completion edge.
REQ-021 byte_out and byte_valid SHALL remain stable until an edge where byte_ready=1 and byte_valid=1; byte_valid then clears unless a new word loads on that same edge.
REQ-022 Completion with byte_valid=0, or with byte_valid=1 and byte_ready=1 on the same edge: load the new word; byte_valid is 1 next cycle.
REQ-023 Completion with byte_valid=1 and byte_ready=0: keep the old word, drop the new one, pulse overrun.
REQ-024 ser_en=1 with ser_start=1 while in DATA or PAR: discard the partial frame, pulse frame_abort, treat the bit as bit 0 (count=1, state DATA).
REQ-025 byte_ready while byte_valid=0 SHALL have no effect.

Reset
REQ-026 With clr=1 at an edge: state IDLE, count 0, shift register 0, byte_out 0, byte_valid 0, overrun 0, frame_abort 0, parity_err 0. clr overrides every other input, and an in-progress frame is lost without a frame_abort pulse.

Configuration
REQ-027 With macro USR_DESER_PARITY_EN defined, each frame carries W data bits plus one parity bit, received in state PAR. The W+1 bits SHALL have even parity. Completion moves to the edge that samples the parity bit. parity_err loads with byte_out, follows the same hold and drop rules, and is 1 on mismatch. The word is delivered regardless of parity_err.
REQ-028 With USR_DESER_PARITY_EN undefined: no PAR state, the frame is W bits, and parity_err is constant 0.

Verification
REQ-029 Send 0xA5 with one bit per cycle, bits 1,0,1,0,0,1,0,1 with ser_start on the first -> byte_out=0xA5, byte_valid high the cycle after the 8th bit, busy low.
REQ-030 Frame 0x3C with ser_en toggling 1,0,1,0,... -> byte_out=0x3C, byte_valid rises only after the 8th enabled bit.
REQ-031 Send 0x11 then 0x22 back-to-back with byte_ready=0 throughout -> byte_out stays 0x11, one overrun pulse; then byte_ready=1 for one cycle -> byte_valid falls.
REQ-032 Five bits of a frame, then ser_start with a new frame 0xF0 -> one frame_abort pulse, byte_out=0xF0, no overrun.
REQ-033 clr=1 after 4 bits, then a full 0x5A frame -> after reset all outputs 0, no pulses; then byte_out=0x5A.
REQ-034 With USR_DESER_PARITY_EN: 0xA5 with parity bit 0 -> parity_err=0; 0xA5 with parity bit 1 -> parity_err=1 and byte_out=0xA5.

Source files
------------

// File: rtl/usr_deser.sv
// LSB-first serial-to-parallel deserializer with a held output word and overrun/abort pulses.
// Define USR_DESER_PARITY_EN to append an even-parity bit to every frame.
module usr_deser #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ser_in,
  input  logic         ser_en,
  input  logic         ser_start,
  output logic [W-1:0] byte_out,
  output logic         byte_valid,
  input  logic         byte_ready,
  output logic         busy,
  output logic         overrun,
  output logic         frame_abort,
  output logic         parity_err
);

  localparam int unsigned CW = $clog2(W + 1);
  localparam logic [CW-1:0] LastCnt = CW'(W - 1);

  typedef enum logic [1:0] {StIdle, StData, StPar} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    shift_q;
  logic [W-1:0]    shift_next;
  logic            done;
  logic [W-1:0]    done_word;
`ifdef USR_DESER_PARITY_EN
  logic            done_par;
`endif

  // The first bit enters at the MSB and reaches bit 0 after W-1 further shifts.
  always_comb begin
    shift_next = {ser_in, shift_q[W-1:1]};
    done       = 1'b0;
    done_word  = shift_next;
`ifdef USR_DESER_PARITY_EN
    done_par   = 1'b0;
    if (ser_en && !ser_start && state_q == StPar) begin
      done      = 1'b1;
      done_word = shift_q;
      done_par  = ^{ser_in, shift_q};
    end
`else
    if (ser_en && !ser_start && state_q == StData && cnt_q == LastCnt) begin
      done = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      byte_out    <= '0;
      byte_valid  <= 1'b0;
      overrun     <= 1'b0;
      frame_abort <= 1'b0;
`ifdef USR_DESER_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      overrun     <= 1'b0;
      frame_abort <= 1'b0;
      if (byte_valid && byte_ready) begin
        byte_valid <= 1'b0;
      end
      if (ser_en) begin
        if (ser_start) begin
          frame_abort <= (state_q != StIdle);
          state_q     <= StData;
          cnt_q       <= CW'(1);
          shift_q     <= {ser_in, {(W-1){1'b0}}};
        end else if (state_q == StData) begin
          shift_q <= shift_next;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
`ifdef USR_DESER_PARITY_EN
            state_q <= StPar;
`else
            state_q <= StIdle;
`endif
          end
        end else if (state_q == StPar) begin
          state_q <= StIdle;
        end
      end
      // A finished word loads only if the output slot is free or being drained now.
      if (done) begin
        if (!byte_valid || byte_ready) begin
          byte_out   <= done_word;
          byte_valid <= 1'b1;
`ifdef USR_DESER_PARITY_EN
          parity_err <= done_par;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

`ifndef USR_DESER_PARITY_EN
  assign parity_err = 1'b0;
`endif

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_usr_deser.sv
// Directed self-checking bench for usr_deser; define USR_DESER_PARITY_EN to also cover parity.
module tb_usr_deser;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         ser_in = 1'b0;
  logic         ser_en = 1'b0;
  logic         ser_start = 1'b0;
  logic [W-1:0] byte_out;
  logic         byte_valid;
  logic         byte_ready = 1'b0;
  logic         busy;
  logic         overrun;
  logic         frame_abort;
  logic         parity_err;

  int n_cmp = 0;
  int n_bad = 0;
  int ov_cnt = 0;
  int ab_cnt = 0;

  usr_deser #(.W(W)) dut (
    .clk        (clk),
    .clr        (clr),
    .ser_in     (ser_in),
    .ser_en     (ser_en),
    .ser_start  (ser_start),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy),
    .overrun    (overrun),
    .frame_abort(frame_abort),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle; tasks compare deltas.
  always @(negedge clk) begin
    if (overrun) ov_cnt = ov_cnt + 1;
    if (frame_abort) ab_cnt = ab_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic start);
    ser_en = 1'b1; ser_in = b; ser_start = start;
    tick();
    ser_en = 1'b0; ser_start = 1'b0; ser_in = 1'b0;
  endtask

  // Last data bit plus the parity bit when parity is compiled in.
  task automatic send_tail(input logic [W-1:0] d, input logic pbit);
    send_bit(d[W-1], 1'b0);
`ifdef USR_DESER_PARITY_EN
    send_bit(pbit, 1'b0);
`endif
  endtask

  task automatic send_frame(input logic [W-1:0] d);
    for (int i = 0; i < W - 1; i++) send_bit(d[i], i == 0);
    send_tail(d, ^d);
  endtask

  task automatic test_reset();
    clr = 1'b1; tick(); tick(); clr = 1'b0;
    n_cmp++;
    if ({byte_out, byte_valid, busy, overrun, frame_abort, parity_err} !== '0) begin
      $display("FAIL reset_outputs got out=%h v=%b busy=%b ov=%b ab=%b pe=%b want all 0",
               byte_out, byte_valid, busy, overrun, frame_abort, parity_err);
      n_bad++;
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] d;
    d = 8'hA5;
    for (int i = 0; i < W - 1; i++) send_bit(d[i], i == 0);
    n_cmp++;
    if (byte_valid !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL basic_midframe got v=%b busy=%b want v=0 busy=1", byte_valid, busy);
      n_bad++;
    end
    send_tail(d, 1'b0);
    n_cmp++;
    if (byte_valid !== 1'b1 || byte_out !== 8'hA5 || busy !== 1'b0) begin
      $display("FAIL basic_word got out=%h v=%b busy=%b want a5 1 0", byte_out, byte_valid, busy);
      n_bad++;
    end
    n_cmp++;
    if (parity_err !== 1'b0) begin
      $display("FAIL basic_parity got %b want 0", parity_err);
      n_bad++;
    end
    tick();
    n_cmp++;
    if (byte_valid !== 1'b1 || byte_out !== 8'hA5) begin
      $display("FAIL basic_hold got out=%h v=%b want a5 1", byte_out, byte_valid);
      n_bad++;
    end
    byte_ready = 1'b1; tick(); byte_ready = 1'b0;
    n_cmp++;
    if (byte_valid !== 1'b0) begin
      $display("FAIL basic_drain got v=%b want 0", byte_valid);
      n_bad++;
    end
  endtask

  task automatic test_gaps();
    logic [W-1:0] d;
    d = 8'h3C;
    for (int i = 0; i < W - 1; i++) begin
      send_bit(d[i], i == 0);
      tick();
    end
    n_cmp++;
    if (byte_valid !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL gaps_early got v=%b busy=%b want 0 1", byte_valid, busy);
      n_bad++;
    end
    send_tail(d, 1'b0);
    n_cmp++;
    if (byte_valid !== 1'b1 || byte_out !== 8'h3C) begin
      $display("FAIL gaps_word got out=%h v=%b want 3c 1", byte_out, byte_valid);
      n_bad++;
    end
    byte_ready = 1'b1; tick(); byte_ready = 1'b0;
  endtask

  task automatic test_overrun();
    int ov0;
    ov0 = ov_cnt;
    send_frame(8'h11);
    send_frame(8'h22);
    tick();
    n_cmp++;
    if (byte_out !== 8'h11 || byte_valid !== 1'b1) begin
      $display("FAIL ovr_keep got out=%h v=%b want 11 1", byte_out, byte_valid);
      n_bad++;
    end
    n_cmp++;
    if (ov_cnt - ov0 !== 1) begin
      $display("FAIL ovr_pulses got %0d want 1", ov_cnt - ov0);
      n_bad++;
    end
    byte_ready = 1'b1; tick(); byte_ready = 1'b0;
    n_cmp++;
    if (byte_valid !== 1'b0) begin
      $display("FAIL ovr_drain got v=%b want 0", byte_valid);
      n_bad++;
    end
  endtask

  task automatic test_abort();
    int ov0;
    int ab0;
    ov0 = ov_cnt; ab0 = ab_cnt;
    // Ready while nothing is held must not matter.
    byte_ready = 1'b1; tick(); byte_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
    send_frame(8'hF0);
    tick();
    n_cmp++;
    if (ab_cnt - ab0 !== 1 || ov_cnt - ov0 !== 0) begin
      $display("FAIL abort_pulses got ab=%0d ov=%0d want 1 0", ab_cnt - ab0, ov_cnt - ov0);
      n_bad++;
    end
    n_cmp++;
    if (byte_out !== 8'hF0 || byte_valid !== 1'b1) begin
      $display("FAIL abort_word got out=%h v=%b want f0 1", byte_out, byte_valid);
      n_bad++;
    end
  endtask

  task automatic test_clr_midframe();
    int ov0;
    int ab0;
    for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0);
    ov0 = ov_cnt; ab0 = ab_cnt;
    clr = 1'b1; tick(); clr = 1'b0;
    n_cmp++;
    if ({byte_out, byte_valid, busy, overrun, frame_abort, parity_err} !== '0) begin
      $display("FAIL clr_outputs got out=%h v=%b busy=%b ov=%b ab=%b pe=%b want all 0",
               byte_out, byte_valid, busy, overrun, frame_abort, parity_err);
      n_bad++;
    end
    send_frame(8'h5A);
    n_cmp++;
    if (byte_out !== 8'h5A || byte_valid !== 1'b1) begin
      $display("FAIL clr_word got out=%h v=%b want 5a 1", byte_out, byte_valid);
      n_bad++;
    end
    tick();
    n_cmp++;
    if (ab_cnt - ab0 !== 0 || ov_cnt - ov0 !== 0) begin
      $display("FAIL clr_pulses got ab=%0d ov=%0d want 0 0", ab_cnt - ab0, ov_cnt - ov0);
      n_bad++;
    end
  endtask

  // Word held (0x5A); a new word completes on the same edge it is drained.
  task automatic test_back_to_back();
    logic [W-1:0] d;
    int ov0;
    d = 8'hC3;
    ov0 = ov_cnt;
    for (int i = 0; i < W - 1; i++) send_bit(d[i], i == 0);
`ifdef USR_DESER_PARITY_EN
    send_bit(d[W-1], 1'b0);
    byte_ready = 1'b1; send_bit(^d, 1'b0); byte_ready = 1'b0;
`else
    byte_ready = 1'b1; send_bit(d[W-1], 1'b0); byte_ready = 1'b0;
`endif
    n_cmp++;
    if (byte_out !== 8'hC3 || byte_valid !== 1'b1) begin
      $display("FAIL b2b_word got out=%h v=%b want c3 1", byte_out, byte_valid);
      n_bad++;
    end
    tick();
    n_cmp++;
    if (ov_cnt - ov0 !== 0) begin
      $display("FAIL b2b_overrun got %0d want 0", ov_cnt - ov0);
      n_bad++;
    end
    byte_ready = 1'b1; tick(); byte_ready = 1'b0;
    n_cmp++;
    if (byte_valid !== 1'b0) begin
      $display("FAIL b2b_drain got v=%b want 0", byte_valid);
      n_bad++;
    end
  endtask

`ifdef USR_DESER_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] d;
    d = 8'hA5;
    for (int i = 0; i < W - 1; i++) send_bit(d[i], i == 0);
    send_bit(d[W-1], 1'b0);
    send_bit(1'b0, 1'b0);
    n_cmp++;
    if (parity_err !== 1'b0 || byte_out !== 8'hA5 || byte_valid !== 1'b1) begin
      $display("FAIL par_good got pe=%b out=%h v=%b want 0 a5 1", parity_err, byte_out, byte_valid);
      n_bad++;
    end
    byte_ready = 1'b1; tick(); byte_ready = 1'b0;
    for (int i = 0; i < W - 1; i++) send_bit(d[i], i == 0);
    send_bit(d[W-1], 1'b0);
    send_bit(1'b1, 1'b0);
    n_cmp++;
    if (parity_err !== 1'b1 || byte_out !== 8'hA5 || byte_valid !== 1'b1) begin
      $display("FAIL par_bad got pe=%b out=%h v=%b want 1 a5 1", parity_err, byte_out, byte_valid);
      n_bad++;
    end
    byte_ready = 1'b1; tick(); byte_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_abort();
    test_clr_midframe();
    test_back_to_back();
`ifdef USR_DESER_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
